// File: rtl/aespim_pkg.sv
// Shared limb geometry and scheduler state encoding for the AES-PIM clmul datapath.
package aespim_pkg;

    localparam int unsigned AESPIM_LIMB_W     = 32;
    localparam int unsigned AESPIM_LIMBS      = 4;
    localparam int unsigned AESPIM_OP_W       = AESPIM_LIMB_W * AESPIM_LIMBS;
    localparam int unsigned AESPIM_PROD_W     = 2 * AESPIM_LIMB_W;
    localparam int unsigned AESPIM_IDX_W      = 3;
    localparam int unsigned AESPIM_LIMB_IDX_W = $clog2(AESPIM_LIMBS);
    localparam int unsigned AESPIM_CNT_W      = $clog2(AESPIM_LIMB_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        OUT  = 2'd2
    } clmul_sched_state_e;

    function automatic logic bpc_legal(input int unsigned bpc);
        return (bpc == 1) || (bpc == 2) || (bpc == 4) ||
               (bpc == 8) || (bpc == 16) || (bpc == 32);
    endfunction

endpackage

// File: rtl/aespim_clmul_sched_if.sv
// Job control and product stream between the clmul scheduler and its neighbours.
interface aespim_clmul_sched_if;
    import aespim_pkg::*;

    logic                     start_i;
    logic                     flush_i;
    logic [AESPIM_OP_W-1:0]   a_i;
    logic [AESPIM_OP_W-1:0]   b_i;
    logic                     prod_ready_i;
    logic                     prod_valid_o;
    logic [AESPIM_PROD_W-1:0] product_o;
    logic [AESPIM_IDX_W-1:0]  shift_idx_o;
    logic                     last_o;
    logic                     busy_o;
    logic                     done_o;

    modport master (
        output start_i, flush_i, a_i, b_i, prod_ready_i,
        input  prod_valid_o, product_o, shift_idx_o, last_o, busy_o, done_o
    );

    modport slave (
        input  start_i, flush_i, a_i, b_i, prod_ready_i,
        output prod_valid_o, product_o, shift_idx_o, last_o, busy_o, done_o
    );

endinterface

// File: rtl/aespim_clmul_step.sv
// One MUL cycle of the limb clmul: XORs BITS_PER_CYCLE shifted copies of a_limb into acc.
module aespim_clmul_step
    import aespim_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 8
) (
    input  logic [AESPIM_LIMB_W-1:0]  i_a_limb,
    input  logic [BITS_PER_CYCLE-1:0] i_b_slice,
    input  logic [AESPIM_CNT_W-1:0]   i_bit_off,
    input  logic [AESPIM_PROD_W-1:0]  i_acc,
    output logic [AESPIM_PROD_W-1:0]  o_acc_c
);

    localparam int unsigned SH_W = AESPIM_CNT_W + 1;

    logic [AESPIM_PROD_W-1:0] w_a_ext;

    assign w_a_ext = {{AESPIM_LIMB_W{1'b0}}, i_a_limb};

    always_comb begin
        o_acc_c = i_acc;
        for (int k = 0; k < int'(BITS_PER_CYCLE); k++) begin
            if (i_b_slice[k]) begin
                o_acc_c = o_acc_c ^ (w_a_ext << (SH_W'(i_bit_off) + SH_W'(k)));
            end
        end
    end

endmodule

// File: rtl/aespim_clmul_sched.sv
// Iterative 128x128 carry-less limb multiplier; streams 16 limb products with shift index i+j.
module aespim_clmul_sched
    import aespim_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    aespim_clmul_sched_if.slave  bus
);

    localparam logic [AESPIM_CNT_W-1:0]      LAST_OFF = AESPIM_CNT_W'(AESPIM_LIMB_W - BITS_PER_CYCLE);
    localparam logic [AESPIM_CNT_W-1:0]      BIT_STEP = AESPIM_CNT_W'(BITS_PER_CYCLE);
    localparam logic [AESPIM_LIMB_IDX_W-1:0] LIMB_MAX = AESPIM_LIMB_IDX_W'(AESPIM_LIMBS - 1);

    if (!bpc_legal(BITS_PER_CYCLE)) begin : g_bad_bpc
        $error("BITS_PER_CYCLE must be one of 1, 2, 4, 8, 16, 32");
    end

    clmul_sched_state_e r_state, w_state_nxt;

    logic [AESPIM_LIMBS-1:0][AESPIM_LIMB_W-1:0] r_a, r_b, w_a_nxt, w_b_nxt;
    logic [AESPIM_LIMB_IDX_W-1:0] r_i, r_j, w_i_nxt, w_j_nxt;
    logic [AESPIM_CNT_W-1:0]      r_bitcnt, w_bitcnt_nxt;
    logic [AESPIM_PROD_W-1:0]     r_acc, w_acc_nxt, w_step_acc;
    logic [AESPIM_PROD_W-1:0]     r_product, w_product_nxt;
    logic [AESPIM_IDX_W-1:0]      r_shift_idx, w_shift_idx_nxt;
    logic                         r_last, w_last_nxt;
    logic                         r_valid, w_valid_nxt;
    logic                         r_busy, w_busy_nxt;
    logic                         r_done, w_done_nxt;

    logic [AESPIM_LIMB_W-1:0]     w_b_limb;
    logic [BITS_PER_CYCLE-1:0]    w_b_slice;
    logic                         w_pair_last;

    assign w_b_limb    = r_b[r_j];
    assign w_b_slice   = BITS_PER_CYCLE'(w_b_limb >> r_bitcnt);
    assign w_pair_last = (r_i == LIMB_MAX) && (r_j == LIMB_MAX);

    aespim_clmul_step #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .i_a_limb  (r_a[r_i]),
        .i_b_slice (w_b_slice),
        .i_bit_off (r_bitcnt),
        .i_acc     (r_acc),
        .o_acc_c   (w_step_acc)
    );

    // Next-state and next-register values; flush overrides everything at the end.
    always_comb begin
        w_state_nxt     = r_state;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_i_nxt         = r_i;
        w_j_nxt         = r_j;
        w_bitcnt_nxt    = r_bitcnt;
        w_acc_nxt       = r_acc;
        w_product_nxt   = r_product;
        w_shift_idx_nxt = r_shift_idx;
        w_last_nxt      = r_last;
        w_done_nxt      = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (bus.start_i) begin
                    w_a_nxt      = bus.a_i;
                    w_b_nxt      = bus.b_i;
                    w_i_nxt      = '0;
                    w_j_nxt      = '0;
                    w_bitcnt_nxt = '0;
                    w_acc_nxt    = '0;
                    w_state_nxt  = MUL;
                end
            end
            MUL: begin
                w_acc_nxt = w_step_acc;
                if (r_bitcnt == LAST_OFF) begin
                    w_product_nxt   = w_step_acc;
                    w_shift_idx_nxt = AESPIM_IDX_W'(r_i) + AESPIM_IDX_W'(r_j);
                    w_last_nxt      = w_pair_last;
                    w_state_nxt     = OUT;
                end else begin
                    w_bitcnt_nxt = r_bitcnt + BIT_STEP;
                end
            end
            OUT: begin
                if (bus.prod_ready_i) begin
                    w_last_nxt = 1'b0;
                    if (w_pair_last) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_j_nxt      = r_j + 1'b1;
                        w_i_nxt      = (r_j == LIMB_MAX) ? r_i + 1'b1 : r_i;
                        w_acc_nxt    = '0;
                        w_bitcnt_nxt = '0;
                        w_state_nxt  = MUL;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (bus.flush_i) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b0;
            w_last_nxt  = 1'b0;
        end

        w_valid_nxt = (w_state_nxt == OUT);
        w_busy_nxt  = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_bitcnt    <= '0;
            r_acc       <= '0;
            r_product   <= '0;
            r_shift_idx <= '0;
            r_last      <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_i         <= w_i_nxt;
            r_j         <= w_j_nxt;
            r_bitcnt    <= w_bitcnt_nxt;
            r_acc       <= w_acc_nxt;
            r_product   <= w_product_nxt;
            r_shift_idx <= w_shift_idx_nxt;
            r_last      <= w_last_nxt;
            r_valid     <= w_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign bus.prod_valid_o = r_valid;
    assign bus.product_o    = r_product;
    assign bus.shift_idx_o  = r_shift_idx;
    assign bus.last_o       = r_last;
    assign bus.busy_o       = r_busy;
    assign bus.done_o       = r_done;

endmodule

// File: doc/aespim_clmul_sched.md
# aespim_clmul_sched

Iterative 128×128 carry-less limb multiplier and scheduler that feeds `aespim_reduce_shift`. It latches two 128-bit operands, splits each into four 32-bit limbs and walks all 16 limb pairs (a_i, b_j). For each pair it computes the 64-bit carry-less product over several cycles and issues it with `shift_idx = i + j` (0..6) on a valid/ready stream. The downstream reduce-shift stage and accumulator consume one product per handshake.

## Interface
Parameters:
- `BITS_PER_CYCLE`, default 8: b-limb bits processed per MUL cycle; legal values are 1, 2, 4, 8, 16 and 32. Any other value is an elaboration error.

Ports:
- `clk_i`  in  1: clock; the block has one clock.
- `rst_ni`  in  1: reset, asynchronous and active-low.
- `start_i`  in  1: launch a job; sampled only in IDLE.
- `flush_i`  in  1: synchronous abort; forces IDLE next cycle.
- `a_i`  in  128: operand A; limb i is `a_i[32i+31:32i]`.
- `b_i`  in  128: operand B; same limb layout.
- `prod_valid_o`  out  1: product and index valid.
- `prod_ready_i`  in  1: downstream accepts.
- `product_o`  out  64: clmul(a_i limb, b_j limb).
- `shift_idx_o`  out  3: i + j.
- `last_o`  out  1: current product is pair (3,3).
- `busy_o`  out  1: state is not IDLE.
- `done_o`  out  1: one-cycle pulse after the last handshake.

## Operation
- The FSM has three states: IDLE, MUL and OUT.
- **IDLE**
  - When `start_i=1`, latch A and B.
  - Clear the pair counters (i=0, j=0), the bit counter and the 64-bit accumulator.
  - Go to MUL.
- **MUL**, each cycle, for k = 0..BITS_PER_CYCLE-1:
  - If `b_limb[bitcnt+k]` is set, `acc ^= {32'b0, a_limb} << (bitcnt+k)`.
  - Then `bitcnt += BITS_PER_CYCLE`.
  - After N = 32/BITS_PER_CYCLE cycles, register acc into `product_o`, register i+j into `shift_idx_o`, and go to OUT.
- **OUT**
  - `prod_valid_o=1`.
  - `product_o`, `shift_idx_o` and `last_o` are held stable until `prod_ready_i=1`.
  - On handshake at pair (3,3): go to IDLE and pulse `done_o` in the next cycle.
  - On handshake at any other pair: advance j; when j wraps 3→0, also do i++.
  - On handshake at any other pair: clear acc and bitcnt, then go to MUL.
- Pair order is i-major: (0,0),(0,1),(0,2),(0,3),(1,0)…(3,3).
- The shift_idx sequence is 0,1,2,3,1,2,3,4,2,3,4,5,3,4,5,6.
- Width rules:
  - Products are exact 63-bit carry-less results; `product_o[63]` is always 0.
  - No reduction is applied here.
- `start_i` outside IDLE is ignored; operands are not re-latched.
- `flush_i` has priority over everything except reset.
  - From any state, next state is IDLE.
  - `prod_valid_o` and `busy_o` drop next cycle.
  - No `done_o` pulse is produced.
- `start_i` and `flush_i` in the same IDLE cycle: flush wins and no job starts.

## Timing
- Reset values: state IDLE.
  - `prod_valid_o`, `busy_o`, `done_o` and `last_o` are 0.
  - `product_o` is 0 and `shift_idx_o` is 0.
  - Internal counters and acc are 0.
- Cycle numbering: `start_i` is sampled at edge 0.
  - MUL occupies cycles 1..N.
  - `prod_valid_o` first rises in cycle N+1; with the default N=4 this is cycle 5.
- With `prod_ready_i` tied high, each pair takes N+1 cycles. A full job takes 16·(N+1) cycles, i.e. 80 at the default.
- `done_o` is asserted in the cycle after the final handshake. In that same cycle `busy_o` is 0 and a new `start_i` is accepted.
- All outputs are registered; there is no combinational path from `prod_ready_i` to any output.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronous). No partial products are issued afterwards.

## Structure
- `aespim_pkg` additions:
  - `AESPIM_LIMB_W = 32` and `AESPIM_LIMBS = 4`.
  - typedef `clmul_sched_state_e` with values {IDLE, MUL, OUT}.
- Sub-module `aespim_clmul_step`: combinational.
  - Inputs: a 32-bit a_limb, a BITS_PER_CYCLE-bit b slice, bit offset and acc_in.
  - Output: acc_out, the XOR of the shifted partial products.
  - The scheduler instantiates it once.
- The scheduler owns the FSM, the operand registers, the i/j/bitcnt counters and the output registers.

## Test plan
- **Single-bit product:** a=1, b=1, ready high.
  - Pair (0,0) gives product 0x1 with shift 0.
  - All other 15 products are 0.
  - Indices follow the listed sequence; `last_o` is set only on the 16th product; `done_o` pulses at cycle 81.
- **Full-limb products:** a=b={4{32'hFFFFFFFF}}.
  - Every product is 0x5555555555555555.
  - With limbs 32'h80000000 instead, every product is 0x4000000000000000.
- **Backpressure:** random ready with 30% duty.
  - Outputs stay stable while valid and not ready.
  - No product is lost or duplicated; the product sequence matches a golden model.
- **Start while busy:** assert `start_i` with new operands in cycle 3 of a job. It is ignored and results match the original operands.
- **Flush:** assert `flush_i` during the OUT of pair (1,2).
  - Next cycle: valid=0 and busy=0, with no `done_o`.
  - A subsequent start runs a clean job.
- **Reset and parameter sweep:**
  - Assert `rst_ni`=0 mid-MUL: all outputs are 0 immediately.
  - Repeat the single-bit test for BITS_PER_CYCLE=1 and 32: first valid at cycle 33 and cycle 2 respectively.
